// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared widths, queue depth default and queue entry type
package fetch_queue_pkg;

  localparam int ADDR_WIDTH        = 32;
  localparam int DATA_WIDTH        = 32;
  localparam int FETCH_QUEUE_DEPTH = 4;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] inst;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_ram.sv
// rtl/fetch_queue_ram.sv - DEPTH-entry storage, synchronous write, asynchronous read
module fetch_queue_ram
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FETCH_QUEUE_DEPTH,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  fq_entry_t     wdata,
  input  logic [PW-1:0] raddr,
  output fq_entry_t     rdata
);

  fq_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - show-ahead fetch-to-decode queue with one-cycle redirect flush
// FETCH_QUEUE_BYPASS_EN: when defined, an empty queue forwards the offered instruction combinationally.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH      = FETCH_QUEUE_DEPTH,
  parameter int ADDR_WIDTH = fetch_queue_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = fetch_queue_pkg::DATA_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [ADDR_WIDTH-1:0]      in_pc,
  input  logic [DATA_WIDTH-1:0]      in_inst,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [ADDR_WIDTH-1:0]      out_pc,
  output logic [DATA_WIDTH-1:0]      out_inst,
  input  logic                       out_pop,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt;
  logic          full, empty;
  logic          push, pop, bypass;
  logic          do_push, do_pop;
  fq_entry_t     in_entry, rd_entry, head;

  assign full     = (cnt == FULL_CNT);
  assign empty    = (cnt == '0);
  assign in_ready = !full;
  assign count    = cnt;

  assign in_entry.pc   = in_pc;
  assign in_entry.inst = in_inst;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = empty & in_valid & !flush;
`else
  assign bypass = 1'b0;
`endif

  assign out_valid = !empty | bypass;
  assign push      = in_valid & in_ready;
  assign pop       = out_pop & out_valid;

  // A bypassed entry that is popped in the same cycle never touches storage.
  assign do_push = push & !(bypass & out_pop);
  assign do_pop  = pop & !bypass;

  always_comb begin
    head = '0;
    if (bypass) begin
      head = in_entry;
    end else if (!empty) begin
      head = rd_entry;
    end
  end

  assign out_pc   = head.pc;
  assign out_inst = head.inst;

  fetch_queue_ram #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_ram (
    .clk   (clk),
    .we    (do_push & !flush & !rst),
    .waddr (wr_ptr),
    .wdata (in_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst && cnt == FULL_CNT) begin
      assert (rd_ptr == wr_ptr);
    end
  end
`endif

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Small show-ahead FIFO between the fetch stage (i_cache output plus fetch PC) and the I→D pipeline register. Fetch keeps running while decode stalls.
- Queue absorbs up to DEPTH fetched instructions.
- Queue presents the oldest one to the I→D register.
- Redirect flush (mispredict recovery) discards all entries in one cycle.

Parameters:
- DEPTH, 4, number of entries; power of two, ≥2.
- ADDR_WIDTH, 32, PC width.
- DATA_WIDTH, 32, instruction width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  discard all entries (branch redirect).
- in_valid  in  1  fetch offers an instruction this cycle.
- in_pc  in  ADDR_WIDTH  PC of offered instruction.
- in_inst  in  DATA_WIDTH  offered instruction word.
- in_ready  out  1  queue accepts an instruction this cycle.
- out_valid  out  1  head entry valid.
- out_pc  out  ADDR_WIDTH  head PC.
- out_inst  out  DATA_WIDTH  head instruction.
- out_pop  in  1  consumer takes head this cycle (I→D register not stalled).
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage: DEPTH-entry array; rd_ptr and wr_ptr of $clog2(DEPTH) bits; count of $clog2(DEPTH)+1 bits.
- Pointers wrap modulo DEPTH naturally.
- full = (count == DEPTH); empty = (count == 0).
- Reset (rst=1 at posedge): rd_ptr=0, wr_ptr=0, count=0.
  - After reset: out_valid=0, in_ready=1, out_pc=0, out_inst=0, count=0.
  - Array contents need no reset.
- in_ready = !full. It does not depend on out_pop, so there is no combinational ready path; a push into a full queue is not accepted even if a pop happens that cycle.
- push = in_valid & in_ready; pop = out_pop & out_valid.
  - out_pop while empty is ignored.
- Show-ahead output:
  - out_valid = !empty.
  - out_pc/out_inst = array[rd_ptr] when !empty, else 0.
- Latency: a pushed entry is visible at the output the cycle after the push (1 cycle).
- Simultaneous push and pop (not full, not empty): both pointers advance; count unchanged.
- Push only: write array[wr_ptr]; wr_ptr+1; count+1.
- Pop only: rd_ptr+1; count-1.
- Flush:
  - Next cycle: rd_ptr = wr_ptr = 0, count = 0.
  - Flush overrides push and pop in the same cycle; the offered instruction is dropped.
  - in_ready is still !full during the flush cycle, but nothing is stored.
- Precedence: rst > flush > push/pop.
- No underflow/overflow possible; count never exceeds DEPTH.
- Assertion (simulation only): count == DEPTH implies rd_ptr == wr_ptr.

Optional Feature:
Macro: FETCH_QUEUE_BYPASS_EN
- Defined: when empty & in_valid & !flush, the output is driven combinationally from the input.
  - out_valid = 1, out_pc = in_pc, out_inst = in_inst.
  - If out_pop is also 1 the same cycle, the entry is consumed without being stored: pointers and count are unchanged (0-cycle latency).
  - If out_pop is 0, the entry is stored as a normal push.
- Undefined: no bypass; out_valid=0 whenever empty; minimum latency is 1 cycle.

Decomposition:
- Shared package (mips_core package): parameter defaults FETCH_QUEUE_DEPTH=4; reuse the existing ADDR_WIDTH and DATA_WIDTH constants.
- Shared package: a packed struct fq_entry_t {pc, inst} used for the array and for the output mux.
- Sub-module: fetch_queue_ram, a DEPTH×(ADDR_WIDTH+DATA_WIDTH) array.
  - Synchronous write, asynchronous read.
  - Keeps pointer and count control separate from storage.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then in_valid=0 → out_valid=0, in_ready=1, count=0, out_pc=0.
- Fill without pop: push pc 0x100, 0x104, 0x108, 0x10C with out_pop=0 → count=4, in_ready=0. A fifth push of 0x110 is rejected. Then pop 4 times → out_pc sequence 0x100, 0x104, 0x108, 0x10C; then out_valid=0.
- Steady stream: push and pop every cycle for 10 cycles starting at 0x200 → count stays 1 after the first cycle; out_pc increments by 4 each cycle; pointers wrap past DEPTH without loss.
- Full with simultaneous pop: at count=4, in_valid=1 (pc 0x300) and out_pop=1 → head popped, 0x300 not accepted, count=3. Next cycle, 0x300 is accepted.
- Flush with push: count=3, flush=1, in_valid=1 (pc 0x400), out_pop=1 → next cycle count=0, out_valid=0. Then push 0x500 → out_pc=0x500 the cycle after.
- Bypass (macro defined): empty queue, in_valid=1 with pc 0x600, out_pop=1 → same cycle out_valid=1, out_pc=0x600; next cycle count=0. With the macro undefined, out_valid=0 in that cycle and count=1 next cycle.
